// File: rtl/cross_bar_rr_pkg.sv
// cross_bar_rr_pkg
//   Shared definitions for the round-robin request/ack crossbar.
//   - default parameter values (master/slave counts, bus widths, watchdog)
//   - addr_t / data_t at the default widths
//   - ERR_DATA, the read data returned on a watchdog completion
//   - arb_state_t, the per-slave arbiter state encoding
//   - addr_to_slave(), which extracts the slave index from an address
package cross_bar_rr_pkg;

  localparam int MASTER_N_DEF    = 4;
  localparam int SLAVE_N_DEF     = 4;
  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 256;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  // Width-adjusted at the point of use (zero-extended or truncated).
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // The slave index lives in the top sel_w bits of an addr_w-bit address.
  // The address is passed zero-extended to 64 bits so one function serves
  // every ADDR_W up to 64.
  function automatic logic [31:0] addr_to_slave(input logic [63:0] addr,
                                                input int          addr_w,
                                                input int          sel_w);
    logic [63:0] sh;
    sh = (addr >> (addr_w - sel_w)) & ((64'd1 << sel_w) - 64'd1);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/cross_bar_rr_if.sv
// cross_bar_rr_if
//   Bundles the master-side and slave-side buses of the crossbar.
//   Master side: master_req/addr/cmd/wdata in, master_ack/rdata out.
//   Slave side : slave_req/addr/cmd/wdata out, slave_ack/rdata in.
//   Modports:
//     slave  - the crossbar's view (it serves the bus masters)
//     master - the environment's view (drives requests, plays the slaves)
interface cross_bar_rr_if #(
  parameter int MASTER_N = 4,
  parameter int SLAVE_N  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);

  logic [MASTER_N-1:0]             master_req;
  logic [MASTER_N-1:0][ADDR_W-1:0] master_addr;
  logic [MASTER_N-1:0]             master_cmd;
  logic [MASTER_N-1:0][DATA_W-1:0] master_wdata;
  logic [MASTER_N-1:0]             master_ack;
  logic [MASTER_N-1:0][DATA_W-1:0] master_rdata;

  logic [SLAVE_N-1:0]              slave_req;
  logic [SLAVE_N-1:0][ADDR_W-1:0]  slave_addr;
  logic [SLAVE_N-1:0]              slave_cmd;
  logic [SLAVE_N-1:0][DATA_W-1:0]  slave_wdata;
  logic [SLAVE_N-1:0]              slave_ack;
  logic [SLAVE_N-1:0][DATA_W-1:0]  slave_rdata;

  modport slave (
    input  master_req, master_addr, master_cmd, master_wdata,
    input  slave_ack, slave_rdata,
    output master_ack, master_rdata,
    output slave_req, slave_addr, slave_cmd, slave_wdata
  );

  modport master (
    output master_req, master_addr, master_cmd, master_wdata,
    output slave_ack, slave_rdata,
    input  master_ack, master_rdata,
    input  slave_req, slave_addr, slave_cmd, slave_wdata
  );

endinterface

// File: rtl/cross_bar_rr_arb.sv
// cross_bar_rr_arb
//   Per-slave round-robin arbiter: picks one requesting master, forwards its
//   request to the slave, and returns the slave's ack/rdata to that master.
//   Optional watchdog under `CROSS_BAR_RR_TIMEOUT_EN`: a BUSY slot that sees
//   no slave_ack for TIMEOUT_CYC cycles completes with ERR_DATA.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant; arbitrate among req_vec starting at ptr
//   BUSY  | grant held; slave bus driven from the granted master
//
// Ports:
//   clk, areset          clock, async active-high reset
//   req_vec              masters whose current request decodes to this slave
//   master_addr/cmd/wdata  full master buses (muxed by grant)
//   slave_req/addr/cmd/wdata  request to this slave
//   slave_ack, slave_rdata    completion from this slave
//   ack_vec, rdata       one-hot master ack and its read data (0 when idle)
module cross_bar_rr_arb
  import cross_bar_rr_pkg::*;
#(
  parameter int MASTER_N    = MASTER_N_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic [MASTER_N-1:0]              req_vec,
  input  logic [MASTER_N-1:0][ADDR_W-1:0]  master_addr,
  input  logic [MASTER_N-1:0]              master_cmd,
  input  logic [MASTER_N-1:0][DATA_W-1:0]  master_wdata,
  output logic                             slave_req,
  output logic [ADDR_W-1:0]                slave_addr,
  output logic                             slave_cmd,
  output logic [DATA_W-1:0]                slave_wdata,
  input  logic                             slave_ack,
  input  logic [DATA_W-1:0]                slave_rdata,
  output logic [MASTER_N-1:0]              ack_vec,
  output logic [DATA_W-1:0]                rdata
);

  localparam int GNT_W = $clog2(MASTER_N);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("cross_bar_rr_arb: TIMEOUT_CYC must be at least 1");
  end

  arb_state_t       state_q, state_d;
  logic [GNT_W-1:0] grant_q, grant_d;
  logic [GNT_W-1:0] ptr_q, ptr_d;
  logic             found;
  logic [GNT_W-1:0] winner;
  logic             tmo_hit;

`ifdef CROSS_BAR_RR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DATA_W-1:0] ERR_DATA_W = DATA_W'(ERR_DATA);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tmo_hit = (state_q == ST_BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYC));

  // Held at zero while IDLE so every BUSY slot starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (!slave_ack && !tmo_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Cyclic first-set search of req_vec beginning at ptr.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < MASTER_N; i++) begin
      idx = (int'(ptr_q) + i) % MASTER_N;
      if (!found && req_vec[idx]) begin
        found  = 1'b1;
        winner = GNT_W'(idx);
      end
    end
  end

  always_comb begin
    logic done;
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    slave_req   = 1'b0;
    slave_addr  = '0;
    slave_cmd   = 1'b0;
    slave_wdata = '0;
    ack_vec     = '0;
    rdata       = '0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          grant_d = winner;
        end
      end

      ST_BUSY: begin
        // On a watchdog hit the request is withdrawn in the completion cycle.
        slave_req   = !tmo_hit;
        slave_addr  = master_addr[grant_q];
        slave_cmd   = master_cmd[grant_q];
        slave_wdata = master_wdata[grant_q];
        // A real ack beats a watchdog hit in the same cycle.
        if (slave_ack) begin
          ack_vec[grant_q] = 1'b1;
          rdata            = slave_rdata;
          done             = 1'b1;
        end else if (tmo_hit) begin
          ack_vec[grant_q] = 1'b1;
`ifdef CROSS_BAR_RR_TIMEOUT_EN
          rdata            = ERR_DATA_W;
`endif
          done             = 1'b1;
        end
        if (done) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = (grant_q == GNT_W'(MASTER_N - 1)) ? '0 : grant_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/cross_bar_rr.sv
// cross_bar_rr
//   MASTER_N x SLAVE_N request/ack crossbar. Each master address is decoded
//   by its top $clog2(SLAVE_N) bits to one slave; every slave has its own
//   registered round-robin arbiter (cross_bar_rr_arb). Acks and read data
//   from all arbiters are OR-merged back onto the master ports; since a
//   master's address selects one slave, at most one arbiter can ack it.
//   Optional watchdog: define CROSS_BAR_RR_TIMEOUT_EN.
//
// Ports:
//   clk     clock, all state on the rising edge
//   areset  asynchronous reset, active-high
//   bus     cross_bar_rr_if.slave: master_req/addr/cmd/wdata in,
//           master_ack/rdata out, slave_req/addr/cmd/wdata out,
//           slave_ack/rdata in
module cross_bar_rr
  import cross_bar_rr_pkg::*;
#(
  parameter int MASTER_N    = MASTER_N_DEF,
  parameter int SLAVE_N     = SLAVE_N_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic           clk,
  input logic           areset,
  cross_bar_rr_if.slave bus
);

  localparam int SEL_W = $clog2(SLAVE_N);

  if (SLAVE_N < 2 || SLAVE_N > 16 || (SLAVE_N & (SLAVE_N - 1)) != 0) begin : g_bad_slave_n
    $error("cross_bar_rr: SLAVE_N must be a power of two in 2..16");
  end
  if (MASTER_N < 2 || MASTER_N > 16) begin : g_bad_master_n
    $error("cross_bar_rr: MASTER_N must be in 2..16");
  end
  if (ADDR_W < SEL_W || ADDR_W > 64) begin : g_bad_addr_w
    $error("cross_bar_rr: ADDR_W must be in SEL_W..64");
  end

  logic [SLAVE_N-1:0]                slv_req;
  logic [SLAVE_N-1:0][ADDR_W-1:0]    slv_addr;
  logic [SLAVE_N-1:0]                slv_cmd;
  logic [SLAVE_N-1:0][DATA_W-1:0]    slv_wdata;
  logic [SLAVE_N-1:0][MASTER_N-1:0]  arb_ack;
  logic [SLAVE_N-1:0][DATA_W-1:0]    arb_rdata;
  logic [MASTER_N-1:0]               ack_or;
  logic [MASTER_N-1:0][DATA_W-1:0]   rdata_or;

  for (genvar s = 0; s < SLAVE_N; s++) begin : g_slave
    logic [MASTER_N-1:0] req_dec;

    for (genvar m = 0; m < MASTER_N; m++) begin : g_dec
      assign req_dec[m] = bus.master_req[m] &&
        (addr_to_slave(64'(bus.master_addr[m]), ADDR_W, SEL_W) == 32'(s));
    end

    cross_bar_rr_arb #(
      .MASTER_N    (MASTER_N),
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_arb (
      .clk          (clk),
      .areset       (areset),
      .req_vec      (req_dec),
      .master_addr  (bus.master_addr),
      .master_cmd   (bus.master_cmd),
      .master_wdata (bus.master_wdata),
      .slave_req    (slv_req[s]),
      .slave_addr   (slv_addr[s]),
      .slave_cmd    (slv_cmd[s]),
      .slave_wdata  (slv_wdata[s]),
      .slave_ack    (bus.slave_ack[s]),
      .slave_rdata  (bus.slave_rdata[s]),
      .ack_vec      (arb_ack[s]),
      .rdata        (arb_rdata[s])
    );
  end

  always_comb begin
    ack_or   = '0;
    rdata_or = '0;
    for (int s = 0; s < SLAVE_N; s++) begin
      for (int m = 0; m < MASTER_N; m++) begin
        if (arb_ack[s][m]) begin
          ack_or[m]   = 1'b1;
          rdata_or[m] = rdata_or[m] | arb_rdata[s];
        end
      end
    end
  end

  assign bus.slave_req    = slv_req;
  assign bus.slave_addr   = slv_addr;
  assign bus.slave_cmd    = slv_cmd;
  assign bus.slave_wdata  = slv_wdata;
  assign bus.master_ack   = ack_or;
  assign bus.master_rdata = rdata_or;

endmodule

// File: tb/tb_cross_bar_rr.sv
// tb_cross_bar_rr
//   Directed bench for cross_bar_rr (4x4, 32-bit, TIMEOUT_CYC=8). Expected
//   master completions are queued when the slave response is driven and
//   consumed by a monitor whenever master_ack fires. Watchdog scenario is
//   checked when CROSS_BAR_RR_TIMEOUT_EN is defined; otherwise the bench
//   checks that BUSY waits past the watchdog length.
module tb_cross_bar_rr;
  import cross_bar_rr_pkg::*;

  localparam int MN  = 4;
  localparam int SN  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  typedef struct packed {
    logic [1:0] m;
    data_t      data;
  } exp_t;

  logic clk = 1'b0;
  logic areset;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cross_bar_rr_if #(.MASTER_N(MN), .SLAVE_N(SN), .ADDR_W(AW), .DATA_W(DW)) bus ();

  cross_bar_rr #(
    .MASTER_N    (MN),
    .SLAVE_N     (SN),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input int m, input logic [31:0] d);
    exp_t e;
    e.m    = 2'(m);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every master_ack must match the oldest expectation.
  always @(negedge clk) begin
    for (int m = 0; m < MN; m++) begin
      if (bus.master_ack[m] === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("sb_spurious_ack_m%0d", m), 64'(bus.master_ack), 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_master", 64'(m), 64'(e.m));
          chk($sformatf("sb_rdata_m%0d", m), 64'(bus.master_rdata[m]), 64'(e.data));
        end
      end
    end
  end

  // Protocol: a pending request must stay asserted until its ack.
  logic [MN-1:0] pend_q;
  always @(posedge clk or posedge areset) begin
    if (areset) pend_q <= '0;
    else        pend_q <= bus.master_req & ~bus.master_ack;
  end
  always @(negedge clk) begin
    if (!areset) begin
      for (int m = 0; m < MN; m++) begin
        assert (!(pend_q[m] && !bus.master_req[m]))
          else $error("FAIL proto_hold: master %0d dropped req before ack", m);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    areset           = 1'b1;
    bus.master_req   = '0;
    bus.master_addr  = '0;
    bus.master_cmd   = '0;
    bus.master_wdata = '0;
    bus.slave_ack    = '0;
    bus.slave_rdata  = '0;

    // Reset state
    smp();
    chk("rst_sreq", 64'(bus.slave_req), 64'h0);
    chk("rst_mack", 64'(bus.master_ack), 64'h0);
    for (int s = 0; s < SN; s++) chk($sformatf("rst_saddr%0d", s), 64'(bus.slave_addr[s]), 64'h0);
    for (int m = 0; m < MN; m++) chk($sformatf("rst_mrdata%0d", m), 64'(bus.master_rdata[m]), 64'h0);
    @(posedge clk);
    #1 areset = 1'b0;
    smp();

    // 1: single read M0 -> slave0
    step();
    bus.master_req[0]  = 1'b1;
    bus.master_addr[0] = 32'h0000_0010;
    bus.master_cmd[0]  = 1'b0;
    smp();
    chk("t1_latency", 64'(bus.slave_req[0]), 64'h0);
    step(); smp();
    chk("t1_sreq", 64'(bus.slave_req[0]), 64'h1);
    chk("t1_saddr", 64'(bus.slave_addr[0]), 64'h10);
    chk("t1_scmd", 64'(bus.slave_cmd[0]), 64'h0);
    step(); smp();
    chk("t1_wait_ack", 64'(bus.master_ack), 64'h0);
    step();
    bus.slave_ack[0]   = 1'b1;
    bus.slave_rdata[0] = 32'hA5A5_0001;
    push(0, 32'hA5A5_0001);
    smp();
    chk("t1_mack", 64'(bus.master_ack), 64'h1);
    chk("t1_mrdata", 64'(bus.master_rdata[0]), 64'hA5A5_0001);
    step();
    bus.slave_ack[0]   = 1'b0;
    bus.slave_rdata[0] = '0;
    bus.master_req[0]  = 1'b0;
    smp();
    chk("t1_sreq_idle", 64'(bus.slave_req[0]), 64'h0);
    chk("t1_mrdata_idle", 64'(bus.master_rdata[0]), 64'h0);

    // 2: all four masters hammer slave1, slave acks every BUSY cycle
    step();
    for (int m = 0; m < MN; m++) begin
      bus.master_req[m]  = 1'b1;
      bus.master_addr[m] = 32'h4000_0000 + 32'(m * 4);
      bus.master_cmd[m]  = 1'b0;
    end
    bus.slave_ack[1] = 1'b1;
    smp();
    chk("t2_arb_cycle", 64'(bus.master_ack), 64'h0);
    for (int c = 0; c < 16; c++) begin
      step();
      // each master leaves after its second completion (cycle after its ack)
      if ((c % 2) == 1 && c >= 9) bus.master_req[((c - 1) / 2) % MN] = 1'b0;
      if ((c % 2) == 0) begin
        bus.slave_rdata[1] = 32'hB000_0000 + 32'(c / 2);
        push((c / 2) % MN, 32'hB000_0000 + 32'(c / 2));
      end
      smp();
      chk($sformatf("t2_order_c%0d", c), 64'(bus.master_ack),
          ((c % 2) == 0) ? (64'h1 << ((c / 2) % MN)) : 64'h0);
    end
    step();
    bus.slave_ack[1]   = 1'b0;
    bus.slave_rdata[1] = '0;
    smp();

    // 3: two slaves in parallel
    step();
    bus.master_req[0]  = 1'b1;
    bus.master_addr[0] = 32'h0000_0020;
    bus.master_req[1]  = 1'b1;
    bus.master_addr[1] = 32'hC000_0000;
    smp();
    chk("t3_no_sreq_yet", 64'(bus.slave_req), 64'h0);
    step(); smp();
    chk("t3_sreq_both", 64'(bus.slave_req), 64'h9);
    chk("t3_saddr3", 64'(bus.slave_addr[3]), 64'hC000_0000);
    chk("t3_saddr0", 64'(bus.slave_addr[0]), 64'h20);
    step();
    bus.slave_ack[3]   = 1'b1;
    bus.slave_rdata[3] = 32'h3333_0003;
    push(1, 32'h3333_0003);
    smp();
    chk("t3_mack1", 64'(bus.master_ack), 64'h2);
    step();
    bus.slave_ack[3]   = 1'b0;
    bus.slave_rdata[3] = '0;
    bus.master_req[1]  = 1'b0;
    bus.slave_ack[0]   = 1'b1;
    bus.slave_rdata[0] = 32'h0000_C0DE;
    push(0, 32'h0000_C0DE);
    smp();
    chk("t3_sreq_s0_only", 64'(bus.slave_req), 64'h1);
    chk("t3_mack0", 64'(bus.master_ack), 64'h1);
    step();
    bus.slave_ack[0]   = 1'b0;
    bus.slave_rdata[0] = '0;
    bus.master_req[0]  = 1'b0;
    smp();

    // 4: reset while slave2 is BUSY for M2; ptr must come back to 0
    step();
    bus.master_req[0]  = 1'b1;
    bus.master_addr[0] = 32'h8000_0000;
    smp();
    step(); smp();
    chk("t4_pre_grant", 64'(bus.slave_addr[2]), 64'h8000_0000);
    step();
    bus.slave_ack[2]   = 1'b1;
    bus.slave_rdata[2] = 32'h2222_0000;
    push(0, 32'h2222_0000);
    smp();
    step();
    bus.slave_ack[2]   = 1'b0;
    bus.slave_rdata[2] = '0;
    bus.master_req[0]  = 1'b0;
    bus.master_req[2]  = 1'b1;
    bus.master_addr[2] = 32'h8000_0008;
    smp();
    step(); smp();
    chk("t4_busy_m2", 64'(bus.slave_addr[2]), 64'h8000_0008);
    #2;
    areset           = 1'b1;
    bus.slave_ack[2] = 1'b1;
    #1;
    chk("t4_rst_sreq", 64'(bus.slave_req[2]), 64'h0);
    chk("t4_rst_mack", 64'(bus.master_ack), 64'h0);
    chk("t4_rst_saddr", 64'(bus.slave_addr[2]), 64'h0);
    @(posedge clk);
    #1;
    areset             = 1'b0;
    bus.slave_ack[2]   = 1'b0;
    bus.master_req[0]  = 1'b1;
    bus.master_addr[0] = 32'h8000_0000;
    smp();
    chk("t4_post_idle", 64'(bus.slave_req[2]), 64'h0);
    step(); smp();
    chk("t4_tie_m0_wins", 64'(bus.slave_addr[2]), 64'h8000_0000);
    step();
    bus.slave_ack[2]   = 1'b1;
    bus.slave_rdata[2] = 32'h2222_0001;
    push(0, 32'h2222_0001);
    smp();
    step();
    bus.slave_ack[2]   = 1'b0;
    bus.master_req[0]  = 1'b0;
    smp();
    step(); smp();
    chk("t4_then_m2", 64'(bus.slave_addr[2]), 64'h8000_0008);
    step();
    bus.slave_ack[2]   = 1'b1;
    bus.slave_rdata[2] = 32'h2222_0002;
    push(2, 32'h2222_0002);
    smp();
    step();
    bus.slave_ack[2]   = 1'b0;
    bus.slave_rdata[2] = '0;
    bus.master_req[2]  = 1'b0;
    smp();

    // 5: write M1 -> slave0, stray ack on idle slave1
    step();
    bus.master_req[1]   = 1'b1;
    bus.master_addr[1]  = 32'h0000_0100;
    bus.master_cmd[1]   = 1'b1;
    bus.master_wdata[1] = 32'h1234_5678;
    bus.slave_ack[1]    = 1'b1;
    smp();
    chk("t5_stray_ack", 64'(bus.master_ack), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(); smp();
      chk($sformatf("t5_scmd_%0d", i), 64'(bus.slave_cmd[0]), 64'h1);
      chk($sformatf("t5_swdata_%0d", i), 64'(bus.slave_wdata[0]), 64'h1234_5678);
      chk($sformatf("t5_mack_%0d", i), 64'(bus.master_ack), 64'h0);
      chk($sformatf("t5_sreq1_%0d", i), 64'(bus.slave_req[1]), 64'h0);
    end
    step();
    bus.slave_ack[1]   = 1'b0;
    bus.slave_ack[0]   = 1'b1;
    bus.slave_rdata[0] = 32'h0000_0000;
    push(1, 32'h0000_0000);
    smp();
    chk("t5_mack", 64'(bus.master_ack), 64'h2);
    step();
    bus.slave_ack[0]    = 1'b0;
    bus.master_req[1]   = 1'b0;
    bus.master_cmd[1]   = 1'b0;
    bus.master_wdata[1] = '0;
    smp();

    // 6: slave1 never acks for M3
    step();
    bus.master_req[3]  = 1'b1;
    bus.master_addr[3] = 32'h4000_0010;
    smp();
    step(); smp();
    chk("t6_sreq_rise", 64'(bus.slave_req[1]), 64'h1);
`ifdef CROSS_BAR_RR_TIMEOUT_EN
    for (int j = 1; j <= TMO; j++) begin
      step();
      if (j == TMO) push(3, 32'hDEAD_BEEF);
      smp();
      if (j < TMO) begin
        chk($sformatf("t6_wait_%0d", j), 64'(bus.master_ack), 64'h0);
      end else begin
        chk("t6_tmo_mack", 64'(bus.master_ack), 64'h8);
        chk("t6_tmo_rdata", 64'(bus.master_rdata[3]), 64'hDEAD_BEEF);
        chk("t6_tmo_sreq", 64'(bus.slave_req[1]), 64'h0);
      end
    end
    step(); smp();
    chk("t6_idle", 64'(bus.slave_req[1]), 64'h0);
    step(); smp();
    chk("t6_regrant", 64'(bus.slave_req[1]), 64'h1);
    for (int j = 1; j <= TMO; j++) begin
      step();
      if (j == TMO) begin
        bus.slave_ack[1]   = 1'b1;
        bus.slave_rdata[1] = 32'h7777_0007;
        push(3, 32'h7777_0007);
      end
      smp();
      if (j == TMO) begin
        chk("t6_race_mack", 64'(bus.master_ack), 64'h8);
        chk("t6_race_rdata", 64'(bus.master_rdata[3]), 64'h7777_0007);
      end
    end
`else
    for (int j = 1; j <= TMO + 4; j++) begin
      step(); smp();
      chk($sformatf("t6_nowdog_mack_%0d", j), 64'(bus.master_ack), 64'h0);
    end
    chk("t6_nowdog_sreq", 64'(bus.slave_req[1]), 64'h1);
    step();
    bus.slave_ack[1]   = 1'b1;
    bus.slave_rdata[1] = 32'h7777_0007;
    push(3, 32'h7777_0007);
    smp();
    chk("t6_late_mack", 64'(bus.master_ack), 64'h8);
`endif
    step();
    bus.slave_ack[1]   = 1'b0;
    bus.slave_rdata[1] = '0;
    bus.master_req[3]  = 1'b0;
    smp();
    step(); smp();

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cross_bar_rr.md
Name: cross_bar_rr

Overview:
Parametrised MASTER_N x SLAVE_N request/ack crossbar with a registered round-robin arbiter per slave.
- Address decode routes each master request to exactly one slave.
- Each slave grants one master at a time and holds the grant until slave_ack.
- Read data and ack return to the granted master only.
- Sits between bus masters (CPU/DMA ports) and memory/peripheral slaves; generalises the fixed-priority, fixed-size crossbar.

Parameters:
MASTER_N, 4, number of master ports (2..16)
SLAVE_N, 4, number of slave ports; power of two, 2..16 (elaboration error otherwise)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYC, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
areset  in  1  asynchronous reset, active-high
master_req  in  MASTER_N  transaction request per master
master_addr  in  MASTER_N x ADDR_W  address; top SEL_W=$clog2(SLAVE_N) bits select the slave
master_cmd  in  MASTER_N  0=read, 1=write
master_wdata  in  MASTER_N x DATA_W  write data
master_ack  out  MASTER_N  transaction complete pulse
master_rdata  out  MASTER_N x DATA_W  read data, valid with master_ack
slave_req  out  SLAVE_N  request to slave
slave_addr  out  SLAVE_N x ADDR_W  full address forwarded unchanged
slave_cmd  out  SLAVE_N  forwarded cmd
slave_wdata  out  SLAVE_N x DATA_W  forwarded write data
slave_ack  in  SLAVE_N  slave completion
slave_rdata  in  SLAVE_N x DATA_W  slave read data, valid with slave_ack

Behaviour:
- Reset (async, immediate):
  - All per-slave states go to IDLE, grants are cleared, round-robin pointers go to 0.
  - slave_req=0 and master_ack=0.
  - slave_addr/cmd/wdata and master_rdata are driven 0 when there is no grant.
- Master protocol:
  - A master holds req, addr, cmd and wdata stable until it sees master_ack.
  - It may deassert req or present a new request in the cycle after the ack.
  - A master deasserting req before ack is a protocol violation; the behaviour is undefined and the bench checks it with an assertion.
- Per-slave FSM, IDLE:
  - Request set R = masters with req=1 whose address selects this slave.
  - If R is non-empty, the winner is the first set bit of R at or after ptr, searched cyclically.
  - At the clock edge, grant is registered and state moves to BUSY.
- Per-slave FSM, BUSY:
  - slave_req=1; slave_addr/cmd/wdata are muxed combinationally from the granted master.
  - When slave_ack=1, master_ack[grant]=1 and master_rdata[grant]=slave_rdata in the same cycle (combinational).
  - At that edge: state goes to IDLE, ptr goes to (grant+1) mod MASTER_N, grant is cleared.
- Latency and throughput:
  - Latency from master_req to slave_req is 1 cycle.
  - Latency from slave_ack to master_ack is 0 cycles.
  - Minimum per-slave cycle is 2 cycles per transaction: the IDLE arbitration cycle is mandatory.
- Parallelism: different slaves run independently; up to min(MASTER_N,SLAVE_N) transactions can be in flight concurrently.
- Exclusivity: a master can be granted by at most one slave, because its single address decodes to one slave.
- slave_ack while IDLE is ignored; no master_ack is generated.
- A master_req change during IDLE is re-evaluated every cycle; there is no latching before grant.
- Fairness: with all masters requesting continuously, each master is served once every MASTER_N transactions.
- Reset asserted mid-transaction: the outstanding transaction is dropped, no ack is delivered, and ptr returns to 0.

Optional Feature:
Macro CROSS_BAR_RR_TIMEOUT_EN.
- With the macro defined:
  - Each slave has a $clog2(TIMEOUT_CYC+1)-bit counter, cleared on entry to BUSY and incremented each BUSY cycle without slave_ack.
  - When the counter reaches TIMEOUT_CYC, the crossbar itself asserts master_ack[grant]=1 with master_rdata=ERR_DATA for one cycle.
  - In that same cycle slave_req drops, then the FSM goes to IDLE and ptr advances as for a normal ack.
  - A slave_ack arriving in the same cycle as the timeout wins: slave data is returned and the counter is ignored.
- Without the macro: no counter; BUSY waits indefinitely.

Decomposition:
- cross_bar_pkg holds:
  - defaults for MASTER_N, SLAVE_N, ADDR_W, DATA_W, TIMEOUT_CYC
  - addr_t and data_t
  - ERR_DATA = 32'hDEAD_BEEF, width-adjusted
  - a function returning the slave index from an address
- Sub-module cross_bar_rr_arb, one instance per slave:
  - contains the FSM, ptr, grant register, the optional timeout counter and the request/return muxes
  - the top contains decode, generate loops and OR-reduction of per-slave master_ack/master_rdata.

Test Plan:
1. Reset, then M0 reads 0x0000_0010 (slave0), slave acks after 3 cycles with rdata 0xA5A5_0001 -> slave_req[0] rises 1 cycle after req; master_ack[0]=1 and master_rdata[0]=0xA5A5_0001 in the ack cycle.
2. M0..M3 continuously target slave1 (addr 0x4000_0000), slave acks every BUSY cycle -> grant order 0,1,2,3,0,1,... and one transaction per 2 cycles.
3. M0 targets slave0 and M1 targets slave3 (0xC000_0000) in the same cycle -> both slave_req assert on the next cycle; both acks are delivered independently.
4. areset pulsed while slave2 is BUSY for M2 -> slave_req[2] drops immediately, no master_ack[2]; after release, ptr=0 (M0 wins a tie with M2).
5. M1 writes 0x1234_5678 to slave0 -> slave_cmd[0]=1 and slave_wdata[0]=0x1234_5678 stable throughout BUSY; a stray slave_ack[1] while slave1 is IDLE produces no master_ack.
6. With CROSS_BAR_RR_TIMEOUT_EN, TIMEOUT_CYC=8, slave never acks -> master_ack=1 with rdata 0xDEAD_BEEF 8 cycles after slave_req rises; slave_ack on exactly that cycle returns slave data instead.
